// File: rtl/nn_pkg.sv
// Shared sizing constants and FSM state encoding for the digit classifier.
package nn_pkg;
    localparam int NUM_PIXELS  = 72;
    localparam int NUM_CLASSES = 10;
    localparam int ACC_W       = 24;
    localparam int PIX_W       = 8;
    localparam int WGT_W       = 8;
    localparam int ADDR_W      = 10;
    localparam int CLS_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        COMPARE,
        DONE
    } state_t;
endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate: unsigned pixel times signed weight into a signed accumulator.
module mac_unit #(
    parameter int ACC_W = 24,
    parameter int PIX_W = 8,
    parameter int WGT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic [PIX_W-1:0]        pixel,
    input  logic signed [WGT_W-1:0] weight,
    output logic signed [ACC_W-1:0] acc
);
    localparam int PROD_W = PIX_W + WGT_W + 1;

    logic signed [PROD_W-1:0] prod;

    // Pixel is zero-extended, weight sign-extended, so the product is exact in PROD_W bits.
    assign prod = $signed({{(WGT_W + 1){1'b0}}, pixel}) *
                  $signed({{(PIX_W + 1){weight[WGT_W-1]}}, weight});

    always_ff @(posedge clk) begin
        if (rst || clear)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/digit_classifier.sv
// Single-layer classifier: scores each class by a dot product over the rotating pixel buffer
// and reports the highest-scoring class.
module digit_classifier #(
    parameter int NUM_PIXELS  = nn_pkg::NUM_PIXELS,
    parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int ACC_W       = nn_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              pixel_in,
    output logic                    network_calc,
    output logic                    shift_network,
    output logic [9:0]              weight_addr,
    input  logic signed [7:0]       weight_data,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              digit,
    output logic signed [ACC_W-1:0] max_score
);
    import nn_pkg::*;

    localparam int PCNT_W = $clog2(NUM_PIXELS);

    state_t                   state, state_nx;
    logic [PCNT_W-1:0]        pix_cnt;
    logic [CLS_W-1:0]         class_cnt;
    logic [PIX_W-1:0]         pix_q;
    logic                     mac_vld;
    logic                     acc_clr;
    logic                     last_pix, last_class, take;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  best_score;
    logic [CLS_W-1:0]         best_idx;

    assign last_pix   = (pix_cnt == PCNT_W'(NUM_PIXELS - 1));
    assign last_class = (class_cnt == CLS_W'(NUM_CLASSES - 1));
    // Class 0 seeds the best unconditionally; later classes must strictly beat it.
    assign take       = (class_cnt == '0) || (acc > best_score);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        acc_clr       = 1'b0;
        network_calc  = (state != IDLE);
        busy          = (state != IDLE);
        shift_network = (state == MAC);
        done          = (state == DONE);
        weight_addr   = '0;
        case (state)
            IDLE: if (start) begin
                state_nx = MAC;
                acc_clr  = 1'b1;
            end
            MAC: begin
                weight_addr = ADDR_W'(class_cnt) * ADDR_W'(NUM_PIXELS) + ADDR_W'(pix_cnt);
                if (last_pix) state_nx = DRAIN;
            end
            DRAIN: state_nx = COMPARE;
            COMPARE: begin
                state_nx = last_class ? DONE : MAC;
                acc_clr  = !last_class;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Weight arrives one cycle after its address, so the pixel is delayed to meet it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt   <= '0;
            class_cnt <= '0;
            pix_q     <= '0;
            mac_vld   <= 1'b0;
        end else begin
            mac_vld <= (state == MAC);
            if (state == MAC) pix_q <= pixel_in;
            pix_cnt <= (state == MAC && !last_pix) ? pix_cnt + 1'b1 : '0;
            if (state == IDLE)
                class_cnt <= '0;
            else if (state == COMPARE)
                class_cnt <= class_cnt + 1'b1;
        end
    end

    mac_unit #(.ACC_W(ACC_W), .PIX_W(PIX_W), .WGT_W(WGT_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clr),
        .en     (mac_vld),
        .pixel  (pix_q),
        .weight (weight_data),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            best_score <= '0;
            best_idx   <= '0;
            digit      <= '0;
            max_score  <= '0;
        end else if (state == COMPARE) begin
            if (take) begin
                best_score <= acc;
                best_idx   <= class_cnt;
            end
            if (last_class) begin
                digit     <= take ? class_cnt : best_idx;
                max_score <= take ? acc : best_score;
            end
        end
    end
endmodule

// File: tb/tb_digit_classifier.sv
// Bench for digit_classifier: rotating pixel buffer model, synchronous weight ROM model,
// and a scoreboard of expected winners computed from the image and weights.
module tb_digit_classifier;
    localparam int NP = 72;
    localparam int NC = 10;

    logic               clk = 1'b0;
    logic               rst, start;
    logic [7:0]         pixel_in;
    logic               network_calc, shift_network, busy, done;
    logic [9:0]         weight_addr;
    logic signed [7:0]  weight_data = '0;
    logic [3:0]         digit;
    logic signed [23:0] max_score;

    digit_classifier dut (
        .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
        .network_calc(network_calc), .shift_network(shift_network),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .busy(busy), .done(done), .digit(digit), .max_score(max_score)
    );

    always #5 clk = ~clk;

    logic [7:0]        pbuf [NP];
    logic [7:0]        img  [NP];
    logic signed [7:0] rom  [NP*NC];
    int                rot = 0;

    always @(posedge clk) begin
        if (shift_network) rot <= (rot == NP - 1) ? 0 : rot + 1;
        weight_data <= (int'(weight_addr) < NP*NC) ? rom[weight_addr] : 8'sd0;
    end
    assign pixel_in = pbuf[rot];

    typedef struct { logic [3:0] digit; int score; } exp_t;
    exp_t sbq[$];

    int nvec = 0;
    int nerr = 0;

    // Place img so the buffer head view (starting at the current rotation) equals img.
    task automatic load_buffer();
        for (int i = 0; i < NP; i++) pbuf[(rot + i) % NP] = img[i];
    endtask

    function automatic int buffer_diffs();
        int n = 0;
        for (int i = 0; i < NP; i++) if (pbuf[(rot + i) % NP] !== img[i]) n++;
        return n;
    endfunction

    function automatic void push_expected();
        exp_t e;
        int best = 0;
        int bidx = 0;
        for (int c = 0; c < NC; c++) begin
            int s = 0;
            for (int k = 0; k < NP; k++) s += int'(img[k]) * int'(rom[c*NP + k]);
            if (c == 0 || s > best) begin best = s; bidx = c; end
        end
        e.digit = 4'(bidx);
        e.score = best;
        sbq.push_back(e);
    endfunction

    // Pulse start, then watch up to 760 cycles counting shifts and done pulses.
    task automatic run_image(input int restart_at, output int dcyc, output int shifts,
                             output int ndone, output logic [3:0] gdig, output int gscore);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        dcyc = -1; shifts = 0; ndone = 0; gdig = '0; gscore = 0;
        for (int c = 0; c <= 760; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            start = (c == restart_at);
            if (shift_network) shifts++;
            if (done) begin
                ndone++;
                if (dcyc < 0) begin dcyc = c; gdig = digit; gscore = int'(max_score); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < NP; i++) begin pbuf[i] = 8'h00; img[i] = 8'h00; end
        for (int i = 0; i < NP*NC; i++) rom[i] = 8'sd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        nvec++; if (network_calc !== 1'b0) begin nerr++; $display("FAIL reset_network_calc got %b want 0", network_calc); end
        nvec++; if (shift_network !== 1'b0) begin nerr++; $display("FAIL reset_shift got %b want 0", shift_network); end
        nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        nvec++; if (digit !== 4'd0 || max_score !== 24'sd0) begin nerr++; $display("FAIL reset_result got %0d/%0d want 0/0", digit, max_score); end
        nvec++; if (weight_addr !== 10'd0) begin nerr++; $display("FAIL reset_weight_addr got %0d want 0", weight_addr); end
    endtask

    task automatic test_zero_weights();
        int dcyc, sh, nd, gs; logic [3:0] gd; exp_t e;
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < NP*NC; i++) rom[i] = 8'sd0;
        load_buffer(); push_expected();
        run_image(-1, dcyc, sh, nd, gd, gs);
        e = sbq.pop_front();
        nvec++; if (dcyc !== 740) begin nerr++; $display("FAIL zero_done_cycle got %0d want 740", dcyc); end
        nvec++; if (sh !== 720) begin nerr++; $display("FAIL zero_shift_count got %0d want 720", sh); end
        nvec++; if (nd !== 1) begin nerr++; $display("FAIL zero_done_pulses got %0d want 1", nd); end
        nvec++; if (gd !== e.digit || gs !== e.score) begin nerr++; $display("FAIL zero_result got %0d/%0d want %0d/%0d", gd, gs, e.digit, e.score); end
        nvec++; if (buffer_diffs() !== 0) begin nerr++; $display("FAIL zero_buffer_order got %0d diffs want 0", buffer_diffs()); end
        nvec++; if (weight_addr !== 10'd0 || busy !== 1'b0) begin nerr++; $display("FAIL zero_idle_after got addr %0d busy %b want 0 0", weight_addr, busy); end
    endtask

    task automatic test_single_weight();
        int dcyc, sh, nd, gs; logic [3:0] gd; exp_t e;
        for (int i = 0; i < NP; i++) img[i] = 8'h00;
        img[5] = 8'd200;
        for (int i = 0; i < NP*NC; i++) rom[i] = 8'sd0;
        rom[3*NP + 5] = 8'sd1;
        load_buffer(); push_expected();
        run_image(-1, dcyc, sh, nd, gd, gs);
        e = sbq.pop_front();
        nvec++; if (gd !== e.digit || gs !== e.score) begin nerr++; $display("FAIL single_result got %0d/%0d want %0d/%0d", gd, gs, e.digit, e.score); end
        nvec++; if (gd !== 4'd3 || gs !== 200) begin nerr++; $display("FAIL single_const got %0d/%0d want 3/200", gd, gs); end
    endtask

    task automatic test_all_negative();
        int dcyc, sh, nd, gs; logic [3:0] gd; exp_t e;
        for (int i = 0; i < NP; i++) img[i] = 8'd1;
        for (int i = 0; i < NP*NC; i++) rom[i] = -8'sd1;
        load_buffer(); push_expected();
        run_image(-1, dcyc, sh, nd, gd, gs);
        e = sbq.pop_front();
        nvec++; if (gd !== e.digit || gs !== e.score) begin nerr++; $display("FAIL neg_tie_result got %0d/%0d want %0d/%0d", gd, gs, e.digit, e.score); end
        nvec++; if (max_score !== -24'sd72) begin nerr++; $display("FAIL neg_hold_score got %0d want -72", max_score); end
    endtask

    task automatic test_tie_low_index();
        int dcyc, sh, nd, gs; logic [3:0] gd; exp_t e;
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < NP*NC; i++) rom[i] = 8'sd0;
        for (int k = 0; k < NP; k++) begin
            rom[4*NP + k] = 8'($urandom_range(1, 127));
            rom[7*NP + k] = rom[4*NP + k];
        end
        load_buffer(); push_expected();
        run_image(-1, dcyc, sh, nd, gd, gs);
        e = sbq.pop_front();
        nvec++; if (gd !== 4'd4) begin nerr++; $display("FAIL tie_digit got %0d want 4", gd); end
        nvec++; if (gs !== e.score) begin nerr++; $display("FAIL tie_score got %0d want %0d", gs, e.score); end
    endtask

    task automatic test_restart_ignored();
        int dcyc, sh, nd, gs; logic [3:0] gd; exp_t e;
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < NP*NC; i++) rom[i] = 8'($urandom_range(0, 255));
        load_buffer(); push_expected();
        run_image(300, dcyc, sh, nd, gd, gs);
        e = sbq.pop_front();
        nvec++; if (dcyc !== 740 || nd !== 1) begin nerr++; $display("FAIL restart_done got cycle %0d pulses %0d want 740 1", dcyc, nd); end
        nvec++; if (gd !== e.digit || gs !== e.score) begin nerr++; $display("FAIL restart_result got %0d/%0d want %0d/%0d", gd, gs, e.digit, e.score); end
        nvec++; if (buffer_diffs() !== 0 || sh !== 720) begin nerr++; $display("FAIL restart_buffer got %0d diffs %0d shifts want 0 720", buffer_diffs(), sh); end
    endtask

    task automatic test_abort();
        int dcyc, sh, nd, gs, ndone_abort; logic [3:0] gd; exp_t e;
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < NP*NC; i++) rom[i] = 8'($urandom_range(0, 255));
        load_buffer();
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone_abort = 0;
        for (int c = 1; c <= 150; c++) begin @(posedge clk); #1; if (done) ndone_abort++; end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL abort_busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        nvec++; if (network_calc !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL abort_idle got nc %b busy %b want 0 0", network_calc, busy); end
        nvec++; if (digit !== 4'd0 || max_score !== 24'sd0) begin nerr++; $display("FAIL abort_result got %0d/%0d want 0/0", digit, max_score); end
        for (int c = 0; c < 700; c++) begin @(posedge clk); #1; if (done) ndone_abort++; end
        nvec++; if (ndone_abort !== 0) begin nerr++; $display("FAIL abort_no_done got %0d want 0", ndone_abort); end
        load_buffer(); push_expected();
        run_image(-1, dcyc, sh, nd, gd, gs);
        e = sbq.pop_front();
        nvec++; if (dcyc !== 740 || gd !== e.digit || gs !== e.score) begin nerr++; $display("FAIL abort_rerun got %0d@%0d/%0d want %0d@740/%0d", gd, dcyc, gs, e.digit, e.score); end
    endtask

    task automatic test_back_to_back();
        int dcyc, sh, nd, gs; logic [3:0] gd; exp_t e;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < NP*NC; i++) rom[i] = 8'($urandom_range(0, 255));
            load_buffer(); push_expected();
            run_image(-1, dcyc, sh, nd, gd, gs);
            nvec++;
            if (sbq.size() == 0) begin nerr++; $display("FAIL b2b_scoreboard got empty want entry"); end
            else begin
                e = sbq.pop_front();
                if (gd !== e.digit || gs !== e.score || dcyc !== 740) begin
                    nerr++; $display("FAIL b2b_result run %0d got %0d/%0d@%0d want %0d/%0d@740", r, gd, gs, dcyc, e.digit, e.score);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_weights();
        test_single_weight();
        test_all_negative();
        test_tie_low_index();
        test_restart_ignored();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/digit_classifier.md
DIGIT_CLASSIFIER -- requirements
Module: digit_classifier

Interface
REQ-001 Parameters: NUM_PIXELS, default 72, number of image bytes in the pixel buffer; NUM_CLASSES, default 10, digits scored; ACC_W, default 24, accumulator width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle pulse: image fully loaded, begin classification.
REQ-005 pixel_in  input  8  unsigned byte currently at the pixel buffer head (buffer's pixel_data_2 output).
REQ-006 network_calc  output  1  buffer ownership: high = classifier drives buffer shifting; SPI shifts blocked.
REQ-007 shift_network  output  1  rotate pixel buffer by one byte this cycle.
REQ-008 weight_addr  output  10  weight ROM address = class*NUM_PIXELS + pixel index.
REQ-009 weight_data  input  8  signed two's-complement weight; valid exactly 1 cycle after weight_addr.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse: digit and max_score updated.
REQ-012 digit  output  4  winning class index.
REQ-013 max_score  output  ACC_W  signed score of winning class.

Function
REQ-014 FSM states IDLE, MAC, DRAIN, COMPARE, DONE; IDLE -> MAC on start; MAC -> DRAIN after NUM_PIXELS cycles; DRAIN -> COMPARE; COMPARE -> MAC (next class) or DONE (last class); DONE -> IDLE unconditionally.
REQ-015 start is accepted only in IDLE; start in any other state is ignored with no effect.
REQ-016 network_calc high in MAC, DRAIN, COMPARE, DONE; low in IDLE.
REQ-017 shift_network high in every MAC cycle only; exactly NUM_PIXELS shifts per class, so the buffer returns to its original order after each class.
REQ-018 In MAC cycle k (k = 0..71) of class c: weight_addr = c*72+k, pixel_in is registered; in the following cycle the product of the registered pixel (zero-extended) and weight_data (sign-extended) is added to the accumulator.
REQ-019 DRAIN performs the final (k = 71) accumulation; accumulator cleared on entry to MAC for each class.
REQ-020 COMPARE: for class 0 the best score/index is loaded unconditionally; for class c > 0 replaced only if acc > best (strict signed compare); ties keep the lower class index.
REQ-021 Accumulator ACC_W = 24 signed; worst-case magnitude 255*128*72 = 2,350,080 fits; no saturation logic.
REQ-022 Per class: 74 cycles; done asserted 740 cycles after the cycle start was sampled (IDLE -> first MAC edge counted as cycle 0).
REQ-023 digit and max_score change only in the DONE cycle and hold until the next DONE.
REQ-024 weight_addr = 0 when not in MAC.

Reset
REQ-025 rst forces IDLE; network_calc, shift_network, busy, done = 0; digit = 0; max_score = 0; accumulator, counters, best registers = 0.
REQ-026 rst mid-operation aborts immediately with no done pulse; buffer may be left partially rotated and must be reloaded by the upstream controller.

Structure
REQ-027 Package nn_pkg holds NUM_PIXELS, NUM_CLASSES, ACC_W, weight/pixel widths and the state enum typedef.
REQ-028 One sub-module mac_unit: registered multiply-accumulate with clear and enable inputs.

Verification
REQ-029 All weights 0, any image -> done at cycle 740, digit 0, max_score 0, exactly 720 shift_network pulses.
REQ-030 Pixel 5 = 200, weight(class 3, pixel 5) = 1, all others 0 -> digit 3, max_score 200.
REQ-031 All weights -1, all pixels 1 -> all scores -72, tie -> digit 0, max_score -72.
REQ-032 Weights of classes 4 and 7 identical and positive, others 0 -> digit 4 (lower index wins tie).
REQ-033 start pulsed again at cycle 300 -> ignored; single done at 740; buffer model contents unchanged after done.
REQ-034 rst at cycle 150 -> next cycle network_calc 0, busy 0, digit 0, max_score 0; no done pulse; fresh start then completes normally.
